turbo_rx_deframer: RTL and testbench
====================================

Name: turbo_rx_deframer

Overview:
- Receive-side counterpart of the turbo encoder control FSM.
- Accepts the encoded symbol stream one triplet per cycle (systematic, parity-1, parity-2 soft values): K data triplets, then 4 trellis-termination (tail) triplets.
- Writes every triplet into the decoder input memory, then hands the complete frame to the turbo decoder through a start/done handshake.
- Sits between the demodulator/LLR quantiser and the decoder core.

Parameters:
- LLR_W, 4, width of one soft value (two's complement)
- LEN_W, 9, width of the block-length input (K up to 511)
- TAIL_LEN, 4, tail triplets per frame (fixed by the encoder)
- ADDR_W, 10, memory address width (must hold K-1+TAIL_LEN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- length  in  LEN_W  block length K; sampled on the first accepted triplet of a frame
- in_valid  in  1  triplet present on in_sys/in_p1/in_p2
- in_sys  in  LLR_W  systematic soft value
- in_p1  in  LLR_W  parity-1 soft value
- in_p2  in  LLR_W  parity-2 soft value
- in_ready  out  1  deframer can accept a triplet
- mem_we  out  1  decoder memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  3*LLR_W  {in_sys, in_p1, in_p2}, with sys in the MSBs
- mem_tail  out  1  current write is a tail triplet
- dec_len  out  LEN_W  latched K, stable from dec_start until dec_done
- dec_start  out  1  one-cycle pulse: frame complete in memory
- dec_done  in  1  decoder finished with the memory
- frame_err  out  1  one-cycle pulse: illegal length (0) at frame start

Behaviour:
- Accept rule: a triplet is accepted in a cycle when in_valid && in_ready.
- in_ready is combinational from state: 1 in IDLE, DATA and TAIL; 0 in START and WAIT_DEC.
- Gaps: in_valid may drop at any time in DATA or TAIL. The FSM holds state and counter. There is no timeout.
- Reset values: state=IDLE, cnt=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_tail=0, dec_len=0, dec_start=0, frame_err=0.
- Write latency: every accepted triplet produces exactly one mem_we pulse on the next cycle, with registered address and data.
- States:
  - IDLE: on accept with length!=0, latch K=length, write at addr 0, cnt<=1.
    - If K==1, go to TAIL with cnt<=0; otherwise go to DATA.
    - On accept with length==0: pulse frame_err, discard the triplet (no write), stay in IDLE.
  - DATA: on accept, write at addr=cnt with mem_tail=0.
    - If cnt==K-1, set cnt<=0 and go to TAIL; otherwise cnt<=cnt+1.
  - TAIL: on accept, write at addr=K+cnt with mem_tail=1.
    - If cnt==TAIL_LEN-1, set cnt<=0 and go to START; otherwise cnt<=cnt+1.
  - START: assert dec_start for exactly one cycle, then go to WAIT_DEC. This is the same cycle the last tail write is on the bus, so the memory is complete when the decoder samples it.
  - WAIT_DEC: hold. On dec_done, go to IDLE. A new frame may be accepted the cycle after.
- dec_done outside WAIT_DEC is ignored.
- The length input is ignored except in IDLE. Changes mid-frame have no effect.
- Arithmetic: the tail address is computed as zero-extended K plus cnt, in ADDR_W bits. No wrap occurs for K≤511.
- Reset mid-frame: abandon the frame immediately. Registered outputs clear on the next edge and no dec_start is issued. A write already in flight is allowed to complete in the reset cycle.
- Total cycles per frame, with no gaps and excluding the decoder wait: K+TAIL_LEN accept cycles, plus 1 START cycle.

Decomposition:
- Shared package turbo_pkg holds:
  - the state encoding localparams (IDLE, DATA, TAIL, START, WAIT_DEC);
  - TAIL_LEN=4, shared with the encoder FSM;
  - LLR_W;
  - the triplet packing order.
- No sub-module is needed. The decoder memory is external, and the FSM and counter live in one module.

Test Plan:
- K=8, continuous in_valid, triplets sys=i, p1=i+1, p2=i+2 -> writes at addr 0..7 with mem_tail=0, then 8..11 with mem_tail=1, data matching. dec_start pulses once, one cycle after the last tail accept. in_ready=0 until dec_done.
- K=1 -> one data write at addr 0, tail writes at addr 1..4, then dec_start.
- K=5 with in_valid low every other cycle -> same 9 writes and addresses as a gap-free run. Counter holds during gaps. dec_start occurs after the 9th accept.
- length=0 with in_valid=1 in IDLE -> frame_err pulse, no mem_we, state stays IDLE. A following triplet with length=3 starts a normal frame.
- reset asserted after the 3rd data accept of a K=10 frame -> no dec_start, in_ready=1 after reset. A fresh frame then writes again from addr 0.
- K=511 full frame -> last tail write at addr 514. dec_len=511 is held until dec_done. A dec_done pulse sent during DATA of the next frame is ignored.

Source files
------------

// File: rtl/turbo_pkg.sv
// Types and constants shared by the turbo encoder control FSM and the receive deframer.
package turbo_pkg;

    localparam int LLR_W    = 4;
    localparam int TAIL_LEN = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL,
        ST_START,
        ST_WAIT_DEC
    } state_t;

    // Triplet packing order in the decoder memory: systematic in the MSBs.
    function automatic logic [3*LLR_W-1:0] pack_triplet(
        input logic [LLR_W-1:0] sys,
        input logic [LLR_W-1:0] p1,
        input logic [LLR_W-1:0] p2
    );
        return {sys, p1, p2};
    endfunction

endpackage

// File: rtl/turbo_rx_deframer_if.sv
// Symbol-stream, decoder-memory and decoder-handshake signals of the receive deframer.
interface turbo_rx_deframer_if #(
    parameter int LEN_W  = 9,
    parameter int ADDR_W = 10
);
    localparam int LW = turbo_pkg::LLR_W;

    logic [LEN_W-1:0]  length;
    logic              in_valid;
    logic [LW-1:0]     in_sys;
    logic [LW-1:0]     in_p1;
    logic [LW-1:0]     in_p2;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3*LW-1:0]   mem_wdata;
    logic              mem_tail;
    logic [LEN_W-1:0]  dec_len;
    logic              dec_start;
    logic              dec_done;
    logic              frame_err;

    // master: demodulator side plus decoder core; slave: the deframer
    modport master (
        output length, in_valid, in_sys, in_p1, in_p2, dec_done,
        input  in_ready, mem_we, mem_addr, mem_wdata, mem_tail, dec_len, dec_start, frame_err
    );
    modport slave (
        input  length, in_valid, in_sys, in_p1, in_p2, dec_done,
        output in_ready, mem_we, mem_addr, mem_wdata, mem_tail, dec_len, dec_start, frame_err
    );
endinterface

// File: rtl/turbo_rx_deframer.sv
// Writes K data triplets plus the tail triplets of a turbo frame into decoder memory,
// then hands the frame to the decoder with a start/done handshake.
module turbo_rx_deframer
    import turbo_pkg::*;
#(
    parameter int LEN_W  = 9,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                reset,
    turbo_rx_deframer_if.slave  bus
);

    state_t              r_state;
    logic [LEN_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    r_k;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [3*LLR_W-1:0]  r_wdata;
    logic                r_tail;
    logic                r_start;
    logic                r_err;

    logic                w_ready;
    logic                w_acc;
    logic [3*LLR_W-1:0]  w_trip;

    assign w_ready = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_TAIL);
    assign w_acc   = bus.in_valid && w_ready;
    assign w_trip  = pack_triplet(bus.in_sys, bus.in_p1, bus.in_p2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_tail  <= 1'b0;
            r_start <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we    <= 1'b0;
            r_start <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_acc) begin
                    if (bus.length == '0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_k     <= bus.length;
                        r_we    <= 1'b1;
                        r_addr  <= '0;
                        r_wdata <= w_trip;
                        r_tail  <= 1'b0;
                        if (bus.length == LEN_W'(1)) begin
                            r_cnt   <= '0;
                            r_state <= ST_TAIL;
                        end else begin
                            r_cnt   <= LEN_W'(1);
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: if (w_acc) begin
                    r_we    <= 1'b1;
                    r_addr  <= ADDR_W'(r_cnt);
                    r_wdata <= w_trip;
                    r_tail  <= 1'b0;
                    if (r_cnt == r_k - LEN_W'(1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_TAIL;
                    end else begin
                        r_cnt <= r_cnt + LEN_W'(1);
                    end
                end
                ST_TAIL: if (w_acc) begin
                    r_we    <= 1'b1;
                    r_addr  <= ADDR_W'(r_k) + ADDR_W'(r_cnt);
                    r_wdata <= w_trip;
                    r_tail  <= 1'b1;
                    if (r_cnt == LEN_W'(TAIL_LEN - 1)) begin
                        // start goes out alongside the last tail write
                        r_cnt   <= '0;
                        r_start <= 1'b1;
                        r_state <= ST_START;
                    end else begin
                        r_cnt <= r_cnt + LEN_W'(1);
                    end
                end
                ST_START:    r_state <= ST_WAIT_DEC;
                ST_WAIT_DEC: if (bus.dec_done) r_state <= ST_IDLE;
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_tail  = r_tail;
    assign bus.dec_len   = r_k;
    assign bus.dec_start = r_start;
    assign bus.frame_err = r_err;

endmodule

// File: tb/tb_turbo_rx_deframer.sv
// Randomized bench for turbo_rx_deframer: a frame-level model predicts every memory write.
module tb_turbo_rx_deframer;
    import turbo_pkg::*;

    localparam int LEN_W  = 9;
    localparam int ADDR_W = 10;
    localparam int DW     = 3 * LLR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DW-1:0]     data;
        logic              tail;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    turbo_rx_deframer_if #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) bus();

    turbo_rx_deframer #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ds_cnt = 0;
    int ds_cyc = -1;
    int fe_cnt = 0;
    int last_acc = 0;
    wr_t exp_q[$];
    wr_t obs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) obs_q.push_back(wr_t'{bus.mem_addr, bus.mem_wdata, bus.mem_tail});
        if (bus.dec_start === 1'b1) begin
            ds_cnt++;
            ds_cyc = cyc;
        end
        if (bus.frame_err === 1'b1) fe_cnt++;
    end

    task automatic clear_mon();
        exp_q.delete();
        obs_q.delete();
        ds_cnt = 0;
        ds_cyc = -1;
        fe_cnt = 0;
    endtask

    // Model: triplet i of a frame of length K lands at address i; tail iff i >= K.
    task automatic send_frame(input int k, input int gap_mode, input bit ramp,
                              input int done_at, input int n);
        for (int i = 0; i < n; i++) begin
            int g;
            int t;
            logic [LLR_W-1:0] s, a, b;
            g = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2 ? int'($urandom_range(0, 2)) : 0);
            repeat (g) begin
                bus.in_valid = 1'b0;
                bus.length   = LEN_W'($urandom);
                @(posedge clk); #1;
            end
            if (ramp) begin
                s = LLR_W'(i); a = LLR_W'(i + 1); b = LLR_W'(i + 2);
            end else begin
                s = LLR_W'($urandom); a = LLR_W'($urandom); b = LLR_W'($urandom);
            end
            bus.in_sys   = s;
            bus.in_p1    = a;
            bus.in_p2    = b;
            bus.length   = (i == 0) ? LEN_W'(k) : LEN_W'($urandom);
            bus.in_valid = 1'b1;
            bus.dec_done = (i == done_at);
            t = 0;
            while (bus.in_ready !== 1'b1 && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (bus.in_ready !== 1'b1) begin
                checks++; errors++;
                $display("FAIL ready_timeout triplet %0d: in_ready=%b, required 1", i, bus.in_ready);
            end
            @(posedge clk); #1;
            last_acc     = cyc;
            bus.in_valid = 1'b0;
            bus.dec_done = 1'b0;
            exp_q.push_back(wr_t'{ADDR_W'(i), {s, a, b}, (i >= k)});
        end
    endtask

    task automatic check_writes(input string name);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d, required %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s write[%0d]: got addr=%0d data=%h tail=%b, required addr=%0d data=%h tail=%b",
                         name, i, obs_q[i].addr, obs_q[i].data, obs_q[i].tail,
                         exp_q[i].addr, exp_q[i].data, exp_q[i].tail);
            end
        end
    endtask

    task automatic finish_frame(input int k, input string name);
        int t;
        t = 0;
        while (ds_cnt == 0 && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (ds_cnt !== 1) begin
            errors++;
            $display("FAIL %s dec_start_count: got %0d, required 1", name, ds_cnt);
        end
        checks++;
        if (ds_cyc !== last_acc) begin
            errors++;
            $display("FAIL %s dec_start_cycle: got %0d, required %0d", name, ds_cyc, last_acc);
        end
        check_writes(name);
        repeat (4) begin
            checks++;
            if (bus.in_ready !== 1'b0 || bus.dec_len !== LEN_W'(k)) begin
                errors++;
                $display("FAIL %s wait_dec: in_ready=%b dec_len=%0d, required 0 and %0d",
                         name, bus.in_ready, bus.dec_len, k);
            end
            @(posedge clk); #1;
        end
        bus.dec_done = 1'b1;
        @(posedge clk); #1;
        bus.dec_done = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || ds_cnt !== 1) begin
            errors++;
            $display("FAIL %s after_done: in_ready=%b dec_starts=%0d, required 1 and 1",
                     name, bus.in_ready, ds_cnt);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 ||
            bus.mem_wdata !== '0 || bus.mem_tail !== 1'b0 || bus.dec_len !== '0 ||
            bus.dec_start !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b we=%b addr=%0d wd=%h tail=%b len=%0d st=%b err=%b, required 1 0 0 0 0 0 0 0",
                     bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_tail,
                     bus.dec_len, bus.dec_start, bus.frame_err);
        end
    endtask

    task automatic test_k8();
        clear_mon();
        send_frame(8, 0, 1'b1, -1, 8 + TAIL_LEN);
        finish_frame(8, "k8");
    endtask

    task automatic test_k1();
        clear_mon();
        send_frame(1, 0, 1'b0, -1, 1 + TAIL_LEN);
        finish_frame(1, "k1");
    endtask

    task automatic test_gaps();
        clear_mon();
        send_frame(5, 1, 1'b0, -1, 5 + TAIL_LEN);
        finish_frame(5, "k5_gaps");
    endtask

    task automatic test_len_zero();
        clear_mon();
        bus.length   = '0;
        bus.in_sys   = LLR_W'($urandom);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (fe_cnt !== 1 || obs_q.size() !== 0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL len_zero: frame_err=%0d writes=%0d in_ready=%b, required 1 0 1",
                     fe_cnt, obs_q.size(), bus.in_ready);
        end
        send_frame(3, 0, 1'b0, -1, 3 + TAIL_LEN);
        finish_frame(3, "after_len_zero");
        checks++;
        if (fe_cnt !== 1) begin
            errors++;
            $display("FAIL len_zero_once: frame_err=%0d, required 1", fe_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_frame(10, 0, 1'b0, -1, 3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (ds_cnt !== 0 || bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.dec_len !== '0) begin
            errors++;
            $display("FAIL reset_mid: dec_starts=%0d in_ready=%b mem_we=%b dec_len=%0d, required 0 1 0 0",
                     ds_cnt, bus.in_ready, bus.mem_we, bus.dec_len);
        end
        check_writes("reset_mid_partial");
        clear_mon();
        send_frame(4, 0, 1'b0, -1, 4 + TAIL_LEN);
        finish_frame(4, "after_reset_mid");
    endtask

    task automatic test_k511();
        clear_mon();
        send_frame(511, 0, 1'b0, -1, 511 + TAIL_LEN);
        finish_frame(511, "k511");
        checks++;
        if (obs_q.size() == 0 || obs_q[obs_q.size()-1].addr !== ADDR_W'(514)) begin
            errors++;
            $display("FAIL k511_last_addr: got %0d, required 514",
                     (obs_q.size() == 0) ? -1 : int'(obs_q[obs_q.size()-1].addr));
        end
        // decoder done pulse landing mid-DATA of the next frame
        clear_mon();
        send_frame(6, 0, 1'b1, 3, 6 + TAIL_LEN);
        finish_frame(6, "done_in_data");
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 6; f++) begin
            int k;
            k = $urandom_range(1, 40);
            clear_mon();
            send_frame(k, 2, 1'b0, int'($urandom_range(0, k + TAIL_LEN)), k + TAIL_LEN);
            finish_frame(k, $sformatf("rand%0d_k%0d", f, k));
        end
    endtask

    initial begin
        bus.length   = '0;
        bus.in_valid = 1'b0;
        bus.in_sys   = '0;
        bus.in_p1    = '0;
        bus.in_p2    = '0;
        bus.dec_done = 1'b0;
        test_reset();
        test_k8();
        test_k1();
        test_gaps();
        test_len_zero();
        test_reset_mid();
        test_k511();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
